// File: rtl/core_pkg.sv
// Shared decode definitions for the in-order core: opcodes, ALU/shift
// sub-op encodings and the decoded-control bundle handed to execute.
package core_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_STD = 7'b0000000;
    localparam logic [6:0] F7_ALT = 7'b0100000;
    localparam logic [6:0] F7_MDU = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLT   = 4'd2,
        ALU_SLTU  = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_OR    = 4'd5,
        ALU_AND   = 4'd6,
        ALU_PASSB = 4'd7,
        ALU_EQ    = 4'd8,
        ALU_NE    = 4'd9,
        ALU_LT    = 4'd10,
        ALU_GE    = 4'd11,
        ALU_LTU   = 4'd12,
        ALU_GEU   = 4'd13
    } alu_ctl_e;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shift_ctl_e;

    typedef struct packed {
        logic       mem_op;
        logic       alu_op;
        logic       mdu_op;
        logic       shift_op;
        alu_ctl_e   alu_control;
        shift_ctl_e shift_control;
        logic       mdu_control;
        logic       rs1_use;
        logic       rs2_use;
        logic       rd_use;
        logic       imm_use;
        logic       is_branch;
        logic [31:0] imm;
        logic [4:0] rs1_value;
        logic [4:0] rs2_value;
        logic [4:0] rd_addr;
    } decode_t;

    // Non-shift arithmetic shares funct3 between OP and OP-IMM
    function automatic alu_ctl_e alu_from_f3(input logic [2:0] f3);
        alu_ctl_e c;
        c = ALU_ADD;
        case (f3)
            3'b010:  c = ALU_SLT;
            3'b011:  c = ALU_SLTU;
            3'b100:  c = ALU_XOR;
            3'b110:  c = ALU_OR;
            3'b111:  c = ALU_AND;
            default: c = ALU_ADD;
        endcase
        return c;
    endfunction

    function automatic alu_ctl_e cmp_from_f3(input logic [2:0] f3);
        alu_ctl_e c;
        c = ALU_EQ;
        case (f3)
            3'b001:  c = ALU_NE;
            3'b100:  c = ALU_LT;
            3'b101:  c = ALU_GE;
            3'b110:  c = ALU_LTU;
            3'b111:  c = ALU_GEU;
            default: c = ALU_EQ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/core_imm_gen.sv
// Combinational immediate generator: picks the I/S/B/U/J format from the
// opcode and sign-extends from instr[31]; other formats yield 0.
module core_imm_gen
    import core_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    logic [6:0]  opcode;
    logic        s;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode = instr[6:0];
    assign s      = instr[31];

    assign imm_i = {{20{s}}, instr[31:20]};
    assign imm_s = {{20{s}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{s}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{s}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};

    always_comb begin
        imm = 32'd0;
        case (opcode)
            OPC_LOAD,
            OPC_OP_IMM,
            OPC_JALR:   imm = imm_i;
            OPC_STORE:  imm = imm_s;
            OPC_BRANCH: imm = imm_b;
            OPC_LUI,
            OPC_AUIPC:  imm = imm_u;
            OPC_JAL:    imm = imm_j;
            default:    imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/rv_core_decode_stage.sv
// RV32I(M) decode stage: combinational decode into one registered bank.
// Define RV_MDU_EN to decode MUL/DIV (funct7=0000001) onto the MDU.
module rv_core_decode_stage
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    output logic        mem_op,
    output logic        alu_op,
    output logic        mdu_op,
    output logic        shift_op,
    output logic [3:0]  alu_control,
    output logic [1:0]  shift_control,
    output logic        mdu_control,
    output logic        rs1_use,
    output logic        rs2_use,
    output logic        rd_use,
    output logic        imm_use,
    output logic        is_branch,
    output logic [31:0] imm,
    output logic [4:0]  rs1_value,
    output logic [4:0]  rs2_value,
    output logic [4:0]  rd_addr
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm_w;
    logic        is_op;
    logic        is_op_imm;
    logic        is_load;
    logic        is_store;
    logic        is_br;
    logic        is_jal;
    logic        is_jalr;
    logic        is_lui;
    logic        std7;
    logic        alt7;
    logic        any_unit;

    decode_t d;
    decode_t q;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign rd     = instr[11:7];

    assign is_op     = opcode == OPC_OP;
    assign is_op_imm = opcode == OPC_OP_IMM;
    assign is_load   = opcode == OPC_LOAD;
    assign is_store  = opcode == OPC_STORE;
    assign is_br     = opcode == OPC_BRANCH;
    assign is_jal    = opcode == OPC_JAL;
    assign is_jalr   = opcode == OPC_JALR;
    assign is_lui    = opcode == OPC_LUI;

    assign std7 = f7 == F7_STD;
    assign alt7 = f7 == F7_ALT;

    core_imm_gen u_imm_gen (
        .instr (instr),
        .imm   (imm_w)
    );

    always_comb begin
        d = '0;
        unique case (1'b1)
            is_op, is_op_imm: begin
                d.rs1_use = 1'b1;
                d.rs2_use = is_op;
                d.imm_use = is_op_imm;
                d.rd_use  = 1'b1;
                case (f3)
                    3'b001: begin
                        if (std7) begin
                            d.shift_op      = 1'b1;
                            d.shift_control = SH_SLL;
                        end
                    end
                    3'b101: begin
                        if (std7) begin
                            d.shift_op      = 1'b1;
                            d.shift_control = SH_SRL;
                        end else if (alt7) begin
                            d.shift_op      = 1'b1;
                            d.shift_control = SH_SRA;
                        end
                    end
                    default: begin
                        if (is_op_imm || std7) begin
                            d.alu_op      = 1'b1;
                            d.alu_control = alu_from_f3(f3);
                        end else if (alt7 && f3 == 3'b000) begin
                            d.alu_op      = 1'b1;
                            d.alu_control = ALU_SUB;
                        end
                    end
                endcase
`ifdef RV_MDU_EN
                if (is_op && f7 == F7_MDU) begin
                    if (f3 == 3'b000) begin
                        d.mdu_op      = 1'b1;
                        d.mdu_control = 1'b0;
                    end else if (f3 == 3'b100) begin
                        d.mdu_op      = 1'b1;
                        d.mdu_control = 1'b1;
                    end
                end
`endif
            end
            is_load: begin
                d.mem_op  = f3 inside {3'b000, 3'b001, 3'b010,
                                       3'b100, 3'b101};
                d.rs1_use = 1'b1;
                d.imm_use = 1'b1;
                d.rd_use  = 1'b1;
            end
            is_store: begin
                d.mem_op  = f3 inside {3'b000, 3'b001, 3'b010};
                d.rs1_use = 1'b1;
                d.rs2_use = 1'b1;
                d.imm_use = 1'b1;
            end
            is_br: begin
                d.alu_op      = !(f3 inside {3'b010, 3'b011});
                d.is_branch   = 1'b1;
                d.alu_control = cmp_from_f3(f3);
                d.rs1_use     = 1'b1;
                d.rs2_use     = 1'b1;
            end
            is_jal: begin
                d.alu_op    = 1'b1;
                d.is_branch = 1'b1;
                d.rd_use    = 1'b1;
            end
            is_jalr: begin
                d.alu_op    = f3 == 3'b000;
                d.is_branch = 1'b1;
                d.rs1_use   = 1'b1;
                d.rd_use    = 1'b1;
            end
            is_lui: begin
                d.alu_op      = 1'b1;
                d.alu_control = ALU_PASSB;
                d.imm_use     = 1'b1;
                d.rd_use      = 1'b1;
            end
            default: d = '0;
        endcase

        // No unit claimed the instruction: collapse everything to a NOP
        any_unit = d.mem_op | d.alu_op | d.mdu_op | d.shift_op;
        if (!any_unit) begin
            d = '0;
        end else begin
            d.imm       = imm_w;
            d.rd_use    = d.rd_use && (rd != 5'd0);
            d.rs1_value = d.rs1_use ? rs1 : 5'd0;
            d.rs2_value = d.rs2_use ? rs2 : 5'd0;
            d.rd_addr   = d.rd_use ? rd : 5'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

    assign mem_op        = q.mem_op;
    assign alu_op        = q.alu_op;
    assign mdu_op        = q.mdu_op;
    assign shift_op      = q.shift_op;
    assign alu_control   = q.alu_control;
    assign shift_control = q.shift_control;
    assign mdu_control   = q.mdu_control;
    assign rs1_use       = q.rs1_use;
    assign rs2_use       = q.rs2_use;
    assign rd_use        = q.rd_use;
    assign imm_use       = q.imm_use;
    assign is_branch     = q.is_branch;
    assign imm           = q.imm;
    assign rs1_value     = q.rs1_value;
    assign rs2_value     = q.rs2_value;
    assign rd_addr       = q.rd_addr;

endmodule

// File: tb/tb_rv_core_decode_stage.sv
// Self-checking bench for rv_core_decode_stage: vector table through a
// scoreboard queue plus hand-written reset sequences.
module tb_rv_core_decode_stage;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        mem_op;
    logic        alu_op;
    logic        mdu_op;
    logic        shift_op;
    logic [3:0]  alu_control;
    logic [1:0]  shift_control;
    logic        mdu_control;
    logic        rs1_use;
    logic        rs2_use;
    logic        rd_use;
    logic        imm_use;
    logic        is_branch;
    logic [31:0] imm;
    logic [4:0]  rs1_value;
    logic [4:0]  rs2_value;
    logic [4:0]  rd_addr;

    rv_core_decode_stage dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .mem_op        (mem_op),
        .alu_op        (alu_op),
        .mdu_op        (mdu_op),
        .shift_op      (shift_op),
        .alu_control   (alu_control),
        .shift_control (shift_control),
        .mdu_control   (mdu_control),
        .rs1_use       (rs1_use),
        .rs2_use       (rs2_use),
        .rd_use        (rd_use),
        .imm_use       (imm_use),
        .is_branch     (is_branch),
        .imm           (imm),
        .rs1_value     (rs1_value),
        .rs2_value     (rs2_value),
        .rd_addr       (rd_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        mem_op;
        logic        alu_op;
        logic        mdu_op;
        logic        shift_op;
        logic [3:0]  alu_control;
        logic [1:0]  shift_control;
        logic        mdu_control;
        logic        rs1_use;
        logic        rs2_use;
        logic        rd_use;
        logic        imm_use;
        logic        is_branch;
        logic [31:0] imm;
        logic [4:0]  rs1_value;
        logic [4:0]  rs2_value;
        logic [4:0]  rd_addr;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        exp_t        exp;
    } vec_t;

    localparam logic [3:0] U_MEM = 4'b1000;
    localparam logic [3:0] U_ALU = 4'b0100;
    localparam logic [3:0] U_MDU = 4'b0010;
    localparam logic [3:0] U_SH  = 4'b0001;

    // Flag order: {rs1_use, rs2_use, rd_use, imm_use, is_branch}
    localparam logic [4:0] F_R  = 5'b11100;
    localparam logic [4:0] F_I  = 5'b10110;

    int passed;
    int total;

    vec_t  vecs[$];
    exp_t  exp_q[$];
    string name_q[$];

    function automatic exp_t ex(
        input logic [3:0]  u,
        input logic [3:0]  ac,
        input logic [1:0]  sc,
        input logic        mc,
        input logic [4:0]  f,
        input logic [31:0] iv,
        input logic [4:0]  r1,
        input logic [4:0]  r2,
        input logic [4:0]  rd
    );
        exp_t e;
        {e.mem_op, e.alu_op, e.mdu_op, e.shift_op} = u;
        e.alu_control   = ac;
        e.shift_control = sc;
        e.mdu_control   = mc;
        {e.rs1_use, e.rs2_use, e.rd_use, e.imm_use, e.is_branch} = f;
        e.imm       = iv;
        e.rs1_value = r1;
        e.rs2_value = r2;
        e.rd_addr   = rd;
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a.mem_op        = mem_op;
        a.alu_op        = alu_op;
        a.mdu_op        = mdu_op;
        a.shift_op      = shift_op;
        a.alu_control   = alu_control;
        a.shift_control = shift_control;
        a.mdu_control   = mdu_control;
        a.rs1_use       = rs1_use;
        a.rs2_use       = rs2_use;
        a.rd_use        = rd_use;
        a.imm_use       = imm_use;
        a.is_branch     = is_branch;
        a.imm           = imm;
        a.rs1_value     = rs1_value;
        a.rs2_value     = rs2_value;
        a.rd_addr       = rd_addr;
        return a;
    endfunction

    task automatic chk(input string nm, input exp_t e);
        exp_t a;
        a = actual();
        total++;
        if (a === e) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic add(input string nm, input logic [31:0] i,
                       input exp_t e);
        vec_t v;
        v.name  = nm;
        v.instr = i;
        v.exp   = e;
        vecs.push_back(v);
    endtask

    exp_t e_add;
    exp_t e_zero;

    initial begin
        passed = 0;
        total  = 0;
        e_zero = '0;
        e_add  = ex(U_ALU, 4'd0, 2'd0, 1'b0, F_R, 32'd0, 5'd5, 5'd1, 5'd31);

        add("add",   32'h00128FB3, e_add);
        add("sub",   32'h40128FB3, ex(U_ALU, 4'd1, 2'd0, 1'b0, F_R, 0, 5, 1, 31));
        add("sll",   32'h00129FB3, ex(U_SH,  4'd0, 2'd0, 1'b0, F_R, 0, 5, 1, 31));
        add("slt",   32'h0012AFB3, ex(U_ALU, 4'd2, 2'd0, 1'b0, F_R, 0, 5, 1, 31));
        add("sltu",  32'h0012BFB3, ex(U_ALU, 4'd3, 2'd0, 1'b0, F_R, 0, 5, 1, 31));
        add("xor",   32'h0012CFB3, ex(U_ALU, 4'd4, 2'd0, 1'b0, F_R, 0, 5, 1, 31));
        add("srl",   32'h0012DFB3, ex(U_SH,  4'd0, 2'd1, 1'b0, F_R, 0, 5, 1, 31));
        add("sra",   32'h4012DFB3, ex(U_SH,  4'd0, 2'd2, 1'b0, F_R, 0, 5, 1, 31));
        add("or",    32'h0012EFB3, ex(U_ALU, 4'd5, 2'd0, 1'b0, F_R, 0, 5, 1, 31));
        add("and",   32'h0012FFB3, ex(U_ALU, 4'd6, 2'd0, 1'b0, F_R, 0, 5, 1, 31));
        add("add_x0", 32'h00128033, ex(U_ALU, 4'd0, 2'd0, 1'b0, 5'b11000, 0, 5, 1, 0));
        add("addi",  32'hFFF10093, ex(U_ALU, 4'd0, 2'd0, 1'b0, F_I, 32'hFFFFFFFF, 2, 0, 1));
        add("srai",  32'h40315093, ex(U_SH,  4'd0, 2'd2, 1'b0, F_I, 32'h403, 2, 0, 1));
        add("lw",    32'h00822183, ex(U_MEM, 4'd0, 2'd0, 1'b0, F_I, 32'd8, 4, 0, 3));
        add("sw",    32'h0020A623, ex(U_MEM, 4'd0, 2'd0, 1'b0, 5'b11010, 32'd12, 1, 2, 0));
        add("beq",   32'hFE208EE3, ex(U_ALU, 4'd8, 2'd0, 1'b0, 5'b11001, 32'hFFFFFFFC, 1, 2, 0));
        add("bgeu",  32'h0020F463, ex(U_ALU, 4'd13, 2'd0, 1'b0, 5'b11001, 32'd8, 1, 2, 0));
        add("lui",   32'h123452B7, ex(U_ALU, 4'd7, 2'd0, 1'b0, 5'b00110, 32'h12345000, 0, 0, 5));
        add("jal",   32'h008000EF, ex(U_ALU, 4'd0, 2'd0, 1'b0, 5'b00101, 32'd8, 0, 0, 1));
        add("jalr",  32'h00008067, ex(U_ALU, 4'd0, 2'd0, 1'b0, 5'b10001, 32'd0, 1, 0, 0));
        add("auipc", 32'h00000097, e_zero);
        add("fence", 32'h0000000F, e_zero);
        add("bad_f7", 32'h20128FB3, e_zero);
        add("bad_br", 32'h0020A463, e_zero);
        add("rem_f3", 32'h0220E1B3, e_zero);
`ifdef RV_MDU_EN
        add("mul",   32'h022081B3, ex(U_MDU, 4'd0, 2'd0, 1'b0, F_R, 0, 1, 2, 3));
        add("div",   32'h0220C1B3, ex(U_MDU, 4'd0, 2'd0, 1'b1, F_R, 0, 1, 2, 3));
`else
        add("mul",   32'h022081B3, e_zero);
        add("div",   32'h0220C1B3, e_zero);
`endif
        add("and_end", 32'h0012FFB3, ex(U_ALU, 4'd6, 2'd0, 1'b0, F_R, 0, 5, 1, 31));

        rst   = 1'b1;
        instr = 32'h00128FB3;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold", e_zero);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("first_after_reset", e_add);

        foreach (vecs[i]) begin
            @(negedge clk);
            instr = vecs[i].instr;
            exp_q.push_back(vecs[i].exp);
            name_q.push_back(vecs[i].name);
            @(posedge clk);
            #1;
            chk(name_q.pop_front(), exp_q.pop_front());
        end

        // Mid-stream asynchronous reset, asserted away from any edge
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async", e_zero);
        @(posedge clk);
        #1;
        chk("rst_held", e_zero);
        @(negedge clk);
        rst   = 1'b0;
        instr = 32'h00128FB3;
        @(posedge clk);
        #1;
        chk("post_rst_add", e_add);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rv_core_decode_stage.md
# rv_core_decode_stage

RV32I(M) instruction decoder for the in-order core pipeline, placed between fetch and execute. It takes the fetched 32-bit instruction and produces registered control for execute and register-file read:

- a one-hot unit select;
- a sub-operation code;
- register addresses and operand-use flags;
- a sign-extended immediate.

## Interface
Parameters: none.

Ports (reset is asynchronous, active-high):
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr  in  32  fetched instruction
- mem_op  out  1  load/store
- alu_op  out  1  ALU operation (arith/logic/compare/branch compare)
- mdu_op  out  1  multiply/divide operation
- shift_op  out  1  shifter operation
- alu_control  out  4  ALU sub-op
- shift_control  out  2  shift sub-op
- mdu_control  out  1  0=MUL, 1=DIV
- rs1_use / rs2_use  out  1  source register read required
- rd_use  out  1  writeback required; 0 when rd=x0
- imm_use  out  1  operand B is imm
- is_branch  out  1  BRANCH, JAL or JALR
- imm  out  32  sign-extended immediate, 0 for R-type
- rs1_value / rs2_value  out  5  source register addresses, 0 when unused
- rd_addr  out  5  destination address, 0 when rd_use=0

## Operation
Unit selects:
- At most one of mem_op, alu_op, mdu_op, shift_op is 1.
- Unsupported opcodes decode as a NOP: every output is 0. This covers AUIPC, FENCE, SYSTEM, and reserved opcodes or funct fields.

alu_control codes:
- ADD=0, SUB=1, SLT=2, SLTU=3, XOR=4, OR=5, AND=6, PASSB=7
- EQ=8, NE=9, LT=10, GE=11, LTU=12, GEU=13

shift_control codes: SLL=0, SRL=1, SRA=2.

Per opcode:
- **OP (0110011)**
  - funct7=0000000 selects ADD, SLT, SLTU, XOR, OR or AND via alu_op, and SLL or SRL via shift_op.
  - funct7=0100000 with funct3 000 gives SUB; with funct3 101 gives SRA.
  - rs1_use=1, rs2_use=1, imm_use=0.
- **OP-IMM (0010011):** same mapping as OP using I-immediate; imm_use=1, rs2_use=0.
  - Shifts use imm[4:0] as the shamt.
  - funct7 bit 30 selects SRAI.
  - No SUBI exists.
- **LOAD (0000011):** mem_op=1, alu_control=ADD, imm=I-imm, rs1_use=1, rd_use=1.
- **STORE (0100011):** mem_op=1, alu_control=ADD, imm=S-imm, rs1_use=1, rs2_use=1, rd_use=0.
- **BRANCH (1100011):** alu_op=1, is_branch=1, compare code from funct3, imm=B-imm, rs1_use=1, rs2_use=1, rd_use=0.
- **JAL:** alu_op=1, is_branch=1, ADD, imm=J-imm, rd_use=1.
- **JALR:** as JAL but imm=I-imm and rs1_use=1.
- **LUI:** alu_op=1, PASSB, imm=U-imm, imm_use=1, rs1_use=0.

Immediate formats: I, S, B, U and J are built per the RV32 spec. B and J have bit0=0. All are sign-extended from instr[31].

## Timing
- Every output is registered: it reflects the instr sampled at the previous rising clk edge (latency 1).
- No handshake. A new instr is accepted every cycle.
- While rst=1, all outputs are 0 immediately (asynchronous) and stay 0. The first valid decode appears one edge after rst deasserts.

## Configuration
- **RV_MDU_EN defined:** OP with funct7=0000001 decodes as follows.
  - funct3 000 → mdu_op=1, mdu_control=0.
  - funct3 100 → mdu_op=1, mdu_control=1.
  - In both cases rs1_use=1, rs2_use=1, rd_use=1.
  - Other funct3 values decode as NOP.
- **RV_MDU_EN undefined:** all funct7=0000001 encodings decode as NOP, and mdu_op/mdu_control are tied to 0.

## Structure
- A shared package core_pkg holds:
  - opcode localparams;
  - the alu_control and shift_control encodings as typed enums;
  - the decoded-control struct.
- One sub-module, core_imm_gen, is combinational: instr in, 32-bit imm for the current format out.
- Decode logic is combinational; a single always_ff register bank holds the outputs.

## Test plan
- **Reset:** assert rst mid-stream → all outputs 0 asynchronously. Deassert, drive 0x00128FB3 → next edge gives alu_op=1, alu_control=0, rs1=5, rs2=1, rd=31, rd_use=1.
- **R-type sweep,** rs1=5, rs2=1, rd=31 throughout:
  - 0x40128FB3 → SUB (1)
  - 0x00129FB3 → shift_op, SLL (0)
  - 0x0012AFB3 → SLT (2)
  - 0x0012BFB3 → SLTU (3)
  - 0x0012CFB3 → XOR (4)
  - 0x0012DFB3 → SRL (1)
  - 0x4012DFB3 → SRA (2)
  - 0x0012EFB3 → OR (5)
  - 0x0012FFB3 → AND (6)
- **ADDI:** 0xFFF10093 → alu_op=1, ADD, imm_use=1, imm=0xFFFFFFFF, rs1=2, rs2_use=0, rd=1.
- **Load:** 0x00822183 (LW x3,8(x4)) → mem_op=1, imm=8, rs1=4, rd=3.
- **Branch:** 0xFE208EE3 (BEQ x1,x2,-4) → is_branch=1, alu_control=8, imm=0xFFFFFFFC, rd_use=0, rd_addr=0.
- **MUL:** 0x022081B3 → with RV_MDU_EN: mdu_op=1, mdu_control=0, rd=3. Without RV_MDU_EN: all outputs 0.
